// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if
//   Bundles every handshake and bus signal of the MEM stage: the EX/MEM
//   valid/ready input, the req/gnt/rvalid data-memory port and the
//   registered valid/ready output toward MEM/WB.
//   Modports:
//     slave  - the MEM stage itself (consumes EX ops, masters the memory port)
//     master - the environment (EX/MEM register, data memory, MEM/WB register)
//   Signals:
//     flush, ls_valid, ts_ready, ts_valid, ns_ready    pipeline control
//     ex_inst/ex_pc/ex_result/ex_rw_en/ex_rw_addr/
//     ex_lsu_data/ex_lsu_op                             incoming EX result
//     data_req/we/addr/wstrb/wdata, data_gnt/rvalid/rdata   memory port
//     wb_inst/wb_pc/wb_result/wb_rw_en/wb_rw_addr/wb_ale    outgoing result
interface mem_stage_lsu_if #(
   parameter int XLEN     = 32,
   parameter int LSU_OP_W = 4
);
   logic                flush;
   logic                ls_valid;
   logic                ts_ready;
   logic                ts_valid;
   logic                ns_ready;

   logic [XLEN-1:0]     ex_inst;
   logic [XLEN-1:0]     ex_pc;
   logic [XLEN-1:0]     ex_result;
   logic                ex_rw_en;
   logic [4:0]          ex_rw_addr;
   logic [XLEN-1:0]     ex_lsu_data;
   logic [LSU_OP_W-1:0] ex_lsu_op;

   logic                data_req;
   logic                data_we;
   logic [XLEN-1:0]     data_addr;
   logic [3:0]          data_wstrb;
   logic [XLEN-1:0]     data_wdata;
   logic                data_gnt;
   logic                data_rvalid;
   logic [XLEN-1:0]     data_rdata;

   logic [XLEN-1:0]     wb_inst;
   logic [XLEN-1:0]     wb_pc;
   logic [XLEN-1:0]     wb_result;
   logic                wb_rw_en;
   logic [4:0]          wb_rw_addr;
   logic                wb_ale;

   modport slave (
      input  flush, ls_valid, ns_ready,
      input  ex_inst, ex_pc, ex_result, ex_rw_en, ex_rw_addr, ex_lsu_data, ex_lsu_op,
      input  data_gnt, data_rvalid, data_rdata,
      output ts_ready, ts_valid,
      output data_req, data_we, data_addr, data_wstrb, data_wdata,
      output wb_inst, wb_pc, wb_result, wb_rw_en, wb_rw_addr, wb_ale
   );

   modport master (
      output flush, ls_valid, ns_ready,
      output ex_inst, ex_pc, ex_result, ex_rw_en, ex_rw_addr, ex_lsu_data, ex_lsu_op,
      output data_gnt, data_rvalid, data_rdata,
      input  ts_ready, ts_valid,
      input  data_req, data_we, data_addr, data_wstrb, data_wdata,
      input  wb_inst, wb_pc, wb_result, wb_rw_en, wb_rw_addr, wb_ale
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//   Consumer end of the EX->MEM pipeline register. Accepts one EX result per
//   ls_valid/ts_ready handshake. Non-memory ops and misaligned accesses go
//   straight to the output register (1 cycle). Aligned loads/stores run a
//   req/gnt/rvalid transaction with byte-lane alignment on the way out and
//   load extension on the way back.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - mem_stage_lsu_if.slave (pipeline handshakes, memory port, WB result)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | ready for a new op (if the output register can take one)
//   S_REQ   | data_req high with stable address/strobes/data, awaiting gnt
//   S_WAIT  | granted, awaiting rvalid; result written on arrival
//   S_DRAIN | flushed after grant; swallow the pending rvalid, then idle
module mem_stage_lsu #(
   parameter int XLEN     = 32,
   parameter int LSU_OP_W = 4
) (
   input  logic           clk,
   input  logic           rst,
   mem_stage_lsu_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;
   typedef enum logic [1:0] {SZ_NONE, SZ_B, SZ_H, SZ_W} size_t;

   localparam logic [LSU_OP_W-1:0] OP_LD_B  = LSU_OP_W'(1);
   localparam logic [LSU_OP_W-1:0] OP_LD_H  = LSU_OP_W'(2);
   localparam logic [LSU_OP_W-1:0] OP_LD_W  = LSU_OP_W'(3);
   localparam logic [LSU_OP_W-1:0] OP_ST_B  = LSU_OP_W'(4);
   localparam logic [LSU_OP_W-1:0] OP_ST_H  = LSU_OP_W'(5);
   localparam logic [LSU_OP_W-1:0] OP_ST_W  = LSU_OP_W'(6);
   localparam logic [LSU_OP_W-1:0] OP_LD_BU = LSU_OP_W'(7);
   localparam logic [LSU_OP_W-1:0] OP_LD_HU = LSU_OP_W'(8);

   state_t              state;

   logic                ts_valid_q;
   logic                data_req_q;
   logic                data_we_q;
   logic [XLEN-1:0]     data_addr_q;
   logic [3:0]          data_wstrb_q;
   logic [XLEN-1:0]     data_wdata_q;
   logic [XLEN-1:0]     wb_inst_q;
   logic [XLEN-1:0]     wb_pc_q;
   logic [XLEN-1:0]     wb_result_q;
   logic                wb_rw_en_q;
   logic [4:0]          wb_rw_addr_q;
   logic                wb_ale_q;

   // Op context held for the duration of a memory transaction
   logic [LSU_OP_W-1:0] lat_op;
   logic [XLEN-1:0]     lat_addr;
   logic [XLEN-1:0]     lat_inst;
   logic [XLEN-1:0]     lat_pc;
   logic                lat_rw_en;
   logic [4:0]          lat_rw_addr;

   logic                ts_ready_c;
   logic                fire;
   size_t               op_size;
   logic                op_load;
   logic                misalign;
   logic [3:0]          st_strb;
   logic [XLEN-1:0]     st_wdata;
   logic [7:0]          ld_byte;
   logic [15:0]         ld_half;
   logic [XLEN-1:0]     ld_value;

   assign ts_ready_c = (state == S_IDLE) && (!ts_valid_q || bus.ns_ready);
   // flush takes priority: an op offered in a flush cycle is dropped
   assign fire       = bus.ls_valid && ts_ready_c && !bus.flush;

   always_comb begin : decode
      op_size  = SZ_NONE;
      op_load  = 1'b0;
      case (bus.ex_lsu_op)
         OP_LD_B, OP_LD_BU: begin op_size = SZ_B; op_load = 1'b1; end
         OP_LD_H, OP_LD_HU: begin op_size = SZ_H; op_load = 1'b1; end
         OP_LD_W:           begin op_size = SZ_W; op_load = 1'b1; end
         OP_ST_B:           op_size = SZ_B;
         OP_ST_H:           op_size = SZ_H;
         OP_ST_W:           op_size = SZ_W;
         default:           op_size = SZ_NONE;
      endcase

      misalign = ((op_size == SZ_H) && bus.ex_result[0]) ||
                 ((op_size == SZ_W) && (bus.ex_result[1:0] != 2'b00));

      st_strb  = 4'b0000;
      st_wdata = bus.ex_lsu_data;
      if (!op_load) begin
         case (op_size)
            SZ_B: begin
               st_strb  = 4'b0001 << bus.ex_result[1:0];
               st_wdata = {4{bus.ex_lsu_data[7:0]}};
            end
            SZ_H: begin
               st_strb  = bus.ex_result[1] ? 4'b1100 : 4'b0011;
               st_wdata = {2{bus.ex_lsu_data[15:0]}};
            end
            SZ_W:    st_strb = 4'b1111;
            default: st_strb = 4'b0000;
         endcase
      end
   end

   always_comb begin : load_align
      ld_byte = bus.data_rdata[7:0];
      case (lat_addr[1:0])
         2'd1:    ld_byte = bus.data_rdata[15:8];
         2'd2:    ld_byte = bus.data_rdata[23:16];
         2'd3:    ld_byte = bus.data_rdata[31:24];
         default: ld_byte = bus.data_rdata[7:0];
      endcase
      ld_half = lat_addr[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];

      case (lat_op)
         OP_LD_B:  ld_value = {{24{ld_byte[7]}}, ld_byte};
         OP_LD_BU: ld_value = {24'h0, ld_byte};
         OP_LD_H:  ld_value = {{16{ld_half[15]}}, ld_half};
         OP_LD_HU: ld_value = {16'h0, ld_half};
         OP_LD_W:  ld_value = bus.data_rdata;
         default:  ld_value = lat_addr;   // stores report their address
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         ts_valid_q   <= 1'b0;
         data_req_q   <= 1'b0;
         data_we_q    <= 1'b0;
         data_addr_q  <= '0;
         data_wstrb_q <= 4'b0000;
         data_wdata_q <= '0;
         wb_inst_q    <= '0;
         wb_pc_q      <= '0;
         wb_result_q  <= '0;
         wb_rw_en_q   <= 1'b0;
         wb_rw_addr_q <= 5'd0;
         wb_ale_q     <= 1'b0;
         lat_op       <= '0;
         lat_addr     <= '0;
         lat_inst     <= '0;
         lat_pc       <= '0;
         lat_rw_en    <= 1'b0;
         lat_rw_addr  <= 5'd0;
      end else begin
         // Downstream took the current result; a new load below overrides
         if (ts_valid_q && bus.ns_ready)
            ts_valid_q <= 1'b0;

         case (state)
            S_IDLE: begin
               if (fire) begin
                  if (op_size == SZ_NONE || misalign) begin
                     ts_valid_q   <= 1'b1;
                     wb_inst_q    <= bus.ex_inst;
                     wb_pc_q      <= bus.ex_pc;
                     wb_result_q  <= bus.ex_result;
                     wb_rw_en_q   <= bus.ex_rw_en && !misalign;
                     wb_rw_addr_q <= bus.ex_rw_addr;
                     wb_ale_q     <= misalign;
                  end else begin
                     lat_op       <= bus.ex_lsu_op;
                     lat_addr     <= bus.ex_result;
                     lat_inst     <= bus.ex_inst;
                     lat_pc       <= bus.ex_pc;
                     lat_rw_en    <= bus.ex_rw_en;
                     lat_rw_addr  <= bus.ex_rw_addr;
                     data_req_q   <= 1'b1;
                     data_we_q    <= !op_load;
                     data_addr_q  <= {bus.ex_result[XLEN-1:2], 2'b00};
                     data_wstrb_q <= st_strb;
                     data_wdata_q <= st_wdata;
                     state        <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (bus.flush) begin
                  data_req_q <= 1'b0;
                  // a grant in the flush cycle still owes us a response
                  state      <= bus.data_gnt ? S_DRAIN : S_IDLE;
               end else if (bus.data_gnt) begin
                  data_req_q <= 1'b0;
                  state      <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.flush) begin
                  state <= bus.data_rvalid ? S_IDLE : S_DRAIN;
               end else if (bus.data_rvalid) begin
                  ts_valid_q   <= 1'b1;
                  wb_inst_q    <= lat_inst;
                  wb_pc_q      <= lat_pc;
                  wb_result_q  <= ld_value;
                  wb_rw_en_q   <= lat_rw_en;
                  wb_rw_addr_q <= lat_rw_addr;
                  wb_ale_q     <= 1'b0;
                  state        <= S_IDLE;
               end
            end
            S_DRAIN: begin
               if (bus.data_rvalid)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         if (bus.flush)
            ts_valid_q <= 1'b0;
      end
   end

   assign bus.ts_ready   = ts_ready_c;
   assign bus.ts_valid   = ts_valid_q;
   assign bus.data_req   = data_req_q;
   assign bus.data_we    = data_we_q;
   assign bus.data_addr  = data_addr_q;
   assign bus.data_wstrb = data_wstrb_q;
   assign bus.data_wdata = data_wdata_q;
   assign bus.wb_inst    = wb_inst_q;
   assign bus.wb_pc      = wb_pc_q;
   assign bus.wb_result  = wb_result_q;
   assign bus.wb_rw_en   = wb_rw_en_q;
   assign bus.wb_rw_addr = wb_rw_addr_q;
   assign bus.wb_ale     = wb_ale_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu
//   Table-driven vectors, hand-written multi-cycle corner sequences and
//   randomized ops checked against a behavioural model of the MEM stage.
module tb_mem_stage_lsu;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   mem_stage_lsu_if #(.XLEN(32), .LSU_OP_W(4)) bus ();

   mem_stage_lsu #(.XLEN(32), .LSU_OP_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic        ale;
      logic        rwen;
      logic        req;
      logic        we;
      logic [3:0]  strb;
      logic [31:0] daddr;
      logic [31:0] wdata;
   } exp_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [31:0] rdata;
      logic        rw_en;
      int          gd;
      int          rd;
      exp_t        e;
   } vec_t;

   typedef struct {
      bit          done;
      int          lat;
      logic        req;
      logic        we;
      logic [3:0]  strb;
      logic [31:0] daddr;
      logic [31:0] wdata;
      logic [31:0] res;
      logic [31:0] inst;
      logic [31:0] pc;
      logic        ale;
      logic        rwen;
      logic [4:0]  rwaddr;
   } obs_t;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Behavioural reference: access size from the op, alignment by modulo,
   // lane data by shifting and multiplying.
   function automatic exp_t model(logic [3:0] op, logic [31:0] addr, logic [31:0] sdata,
                                  logic [31:0] rdata, logic rw_en);
      exp_t        e;
      int          size;
      bit          load;
      logic [31:0] lane;
      e = '{default: 0};
      size = 0;
      load = 0;
      case (op)
         4'd1, 4'd7: begin size = 1; load = 1; end
         4'd2, 4'd8: begin size = 2; load = 1; end
         4'd3:       begin size = 4; load = 1; end
         4'd4:       size = 1;
         4'd5:       size = 2;
         4'd6:       size = 4;
         default:    size = 0;
      endcase
      e.res = addr;
      if (size == 0) begin
         e.rwen = rw_en;
         return e;
      end
      if (addr % size != 0) begin
         e.ale = 1'b1;
         return e;
      end
      e.req   = 1'b1;
      e.rwen  = rw_en;
      e.daddr = addr - (addr % 4);
      if (load) begin
         lane = rdata >> (8 * (addr % 4));
         case (op)
            4'd1:    e.res = 32'($signed(lane[7:0]));
            4'd7:    e.res = 32'(lane[7:0]);
            4'd2:    e.res = 32'($signed(lane[15:0]));
            4'd8:    e.res = 32'(lane[15:0]);
            default: e.res = rdata;
         endcase
      end else begin
         e.we    = 1'b1;
         e.strb  = 4'(((1 << size) - 1) << (addr % 4));
         e.wdata = (size == 1) ? sdata[7:0] * 32'h0101_0101 :
                   (size == 2) ? sdata[15:0] * 32'h0001_0001 : sdata;
      end
      return e;
   endfunction

   function automatic vec_t mk(logic [3:0] op, logic [31:0] addr, logic [31:0] sdata,
                               logic [31:0] rdata, logic rw_en, int gd, int rd,
                               logic [31:0] res, logic ale, logic rwen, logic req, logic we,
                               logic [3:0] strb, logic [31:0] daddr, logic [31:0] wdata);
      vec_t v;
      v.op = op; v.addr = addr; v.sdata = sdata; v.rdata = rdata; v.rw_en = rw_en;
      v.gd = gd; v.rd = rd;
      v.e.res = res; v.e.ale = ale; v.e.rwen = rwen; v.e.req = req; v.e.we = we;
      v.e.strb = strb; v.e.daddr = daddr; v.e.wdata = wdata;
      return v;
   endfunction

   task automatic idle_inputs();
      bus.flush       = 1'b0;
      bus.ls_valid    = 1'b0;
      bus.ns_ready    = 1'b1;
      bus.ex_inst     = '0;
      bus.ex_pc       = '0;
      bus.ex_result   = '0;
      bus.ex_rw_en    = 1'b0;
      bus.ex_rw_addr  = '0;
      bus.ex_lsu_data = '0;
      bus.ex_lsu_op   = '0;
      bus.data_gnt    = 1'b0;
      bus.data_rvalid = 1'b0;
      bus.data_rdata  = '0;
   endtask

   task automatic present(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic rw_en, input logic [31:0] inst, input logic [31:0] pc,
                          input logic [4:0] rwa);
      bus.ls_valid    = 1'b1;
      bus.ex_lsu_op   = op;
      bus.ex_result   = addr;
      bus.ex_lsu_data = sdata;
      bus.ex_rw_en    = rw_en;
      bus.ex_inst     = inst;
      bus.ex_pc       = pc;
      bus.ex_rw_addr  = rwa;
   endtask

   // One op end to end, memory answering after gd grant-wait and rd
   // response-wait cycles. lat counts negedges from the accept edge.
   task automatic run_op(input vec_t v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [4:0] rwa, output obs_t o);
      int  k;
      int  req_cnt;
      int  wait_cnt;
      bit  granted;
      o = '{default: 0};
      @(negedge clk);
      bus.ns_ready = 1'b1;
      present(v.op, v.addr, v.sdata, v.rw_en, inst, pc, rwa);
      k = 0;
      while (!bus.ts_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!bus.ts_ready) begin
         cmp("accept_timeout", 32'(bus.ts_ready), 32'd1);
         bus.ls_valid = 1'b0;
         return;
      end
      @(negedge clk);
      bus.ls_valid    = 1'b0;
      bus.ex_result   = $urandom;
      bus.ex_inst     = $urandom;
      bus.ex_pc       = $urandom;
      bus.ex_lsu_data = $urandom;
      bus.ex_rw_addr  = 5'($urandom);
      req_cnt  = 0;
      wait_cnt = 0;
      granted  = 0;
      for (int c = 0; c < 40; c++) begin
         bus.data_gnt    = 1'b0;
         bus.data_rvalid = 1'b0;
         bus.data_rdata  = $urandom;
         if (bus.ts_valid) begin
            o.done   = 1;
            o.lat    = c;
            o.res    = bus.wb_result;
            o.inst   = bus.wb_inst;
            o.pc     = bus.wb_pc;
            o.ale    = bus.wb_ale;
            o.rwen   = bus.wb_rw_en;
            o.rwaddr = bus.wb_rw_addr;
            break;
         end
         if (bus.data_req) begin
            o.req = 1'b1;
            if (req_cnt == v.gd) begin
               o.we         = bus.data_we;
               o.strb       = bus.data_wstrb;
               o.daddr      = bus.data_addr;
               o.wdata      = bus.data_wdata;
               bus.data_gnt = 1'b1;
               granted      = 1;
            end
            req_cnt++;
         end else if (granted) begin
            if (wait_cnt == v.rd) begin
               bus.data_rvalid = 1'b1;
               bus.data_rdata  = v.rdata;
            end
            wait_cnt++;
         end
         @(negedge clk);
      end
      bus.data_gnt    = 1'b0;
      bus.data_rvalid = 1'b0;
   endtask

   task automatic check_obs(input string tag, input vec_t v, input obs_t o,
                            input logic [31:0] inst, input logic [31:0] pc, input logic [4:0] rwa);
      cmp({tag, "_done"}, 32'(o.done), 32'd1);
      if (o.done) begin
         cmp({tag, "_result"}, o.res, v.e.res);
         cmp({tag, "_ale"}, 32'(o.ale), 32'(v.e.ale));
         cmp({tag, "_rw_en"}, 32'(o.rwen), 32'(v.e.rwen));
         cmp({tag, "_req_seen"}, 32'(o.req), 32'(v.e.req));
         cmp({tag, "_latency"}, 32'(o.lat), v.e.req ? 32'(2 + v.gd + v.rd) : 32'd0);
         cmp({tag, "_inst"}, o.inst, inst);
         cmp({tag, "_pc"}, o.pc, pc);
         cmp({tag, "_rw_addr"}, 32'(o.rwaddr), 32'(rwa));
      end
      if (v.e.req) begin
         cmp({tag, "_we"}, 32'(o.we), 32'(v.e.we));
         cmp({tag, "_wstrb"}, 32'(o.strb), 32'(v.e.strb));
         cmp({tag, "_addr"}, o.daddr, v.e.daddr);
         if (v.e.we)
            cmp({tag, "_wdata"}, o.wdata, v.e.wdata);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[15];
      vec_t v;
      obs_t o;
      logic [31:0] inst;
      logic [31:0] pc;
      logic [4:0]  rwa;

      idle_inputs();

      // op  addr  sdata  rdata  rw_en gd rd | result ale rwen req we strb daddr wdata
      vecs[0]  = mk(4'd0, 32'h0000_1234, 32'h0, 32'h0, 1'b1, 0, 0, 32'h0000_1234, 0, 1, 0, 0, 4'b0000, 32'h0, 32'h0);
      vecs[1]  = mk(4'd1, 32'h0000_0103, 32'h0, 32'h80FF_FF00, 1'b1, 0, 0, 32'hFFFF_FF80, 0, 1, 1, 0, 4'b0000, 32'h100, 32'h0);
      vecs[2]  = mk(4'd7, 32'h0000_0103, 32'h0, 32'h80FF_FF00, 1'b1, 0, 0, 32'h0000_0080, 0, 1, 1, 0, 4'b0000, 32'h100, 32'h0);
      vecs[3]  = mk(4'd5, 32'h0000_0102, 32'hAAAA_BEEF, 32'h0, 1'b0, 0, 0, 32'h0000_0102, 0, 0, 1, 1, 4'b1100, 32'h100, 32'hBEEF_BEEF);
      vecs[4]  = mk(4'd3, 32'h0000_0101, 32'h0, 32'h0, 1'b1, 0, 0, 32'h0000_0101, 1, 0, 0, 0, 4'b0000, 32'h0, 32'h0);
      vecs[5]  = mk(4'd2, 32'h0000_0206, 32'h0, 32'h8001_7FFF, 1'b1, 1, 0, 32'hFFFF_8001, 0, 1, 1, 0, 4'b0000, 32'h204, 32'h0);
      vecs[6]  = mk(4'd8, 32'h0000_0204, 32'h0, 32'h1234_F00D, 1'b1, 0, 1, 32'h0000_F00D, 0, 1, 1, 0, 4'b0000, 32'h204, 32'h0);
      vecs[7]  = mk(4'd2, 32'h0000_0204, 32'h0, 32'h1234_F00D, 1'b1, 0, 0, 32'hFFFF_F00D, 0, 1, 1, 0, 4'b0000, 32'h204, 32'h0);
      vecs[8]  = mk(4'd4, 32'h0000_0301, 32'h1122_3344, 32'h0, 1'b0, 0, 0, 32'h0000_0301, 0, 0, 1, 1, 4'b0010, 32'h300, 32'h4444_4444);
      vecs[9]  = mk(4'd6, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0, 1'b0, 1, 2, 32'h0000_0400, 0, 0, 1, 1, 4'b1111, 32'h400, 32'hDEAD_BEEF);
      vecs[10] = mk(4'd3, 32'h0000_0408, 32'h0, 32'hCAFE_F00D, 1'b1, 2, 3, 32'hCAFE_F00D, 0, 1, 1, 0, 4'b0000, 32'h408, 32'h0);
      vecs[11] = mk(4'd8, 32'h0000_0103, 32'h0, 32'h0, 1'b1, 0, 0, 32'h0000_0103, 1, 0, 0, 0, 4'b0000, 32'h0, 32'h0);
      vecs[12] = mk(4'd6, 32'h0000_0402, 32'h0, 32'h0, 1'b0, 0, 0, 32'h0000_0402, 1, 0, 0, 0, 4'b0000, 32'h0, 32'h0);
      vecs[13] = mk(4'd1, 32'h0000_0100, 32'h0, 32'h0000_007F, 1'b1, 0, 0, 32'h0000_007F, 0, 1, 1, 0, 4'b0000, 32'h100, 32'h0);
      vecs[14] = mk(4'd7, 32'h0000_0102, 32'h0, 32'h00AB_0000, 1'b1, 0, 0, 32'h0000_00AB, 0, 1, 1, 0, 4'b0000, 32'h100, 32'h0);

      // Reset values
      #3;
      cmp("rst_ts_valid", 32'(bus.ts_valid), 32'd0);
      cmp("rst_data_req", 32'(bus.data_req), 32'd0);
      cmp("rst_data_we", 32'(bus.data_we), 32'd0);
      cmp("rst_data_wstrb", 32'(bus.data_wstrb), 32'd0);
      cmp("rst_wb_result", bus.wb_result, 32'd0);
      cmp("rst_wb_ale", 32'(bus.wb_ale), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      cmp("post_rst_ts_ready", 32'(bus.ts_ready), 32'd1);

      // Table vectors
      for (int i = 0; i < 15; i++) begin
         inst = 32'h0000_1000 + 32'(i);
         pc   = 32'(i) * 4;
         rwa  = 5'(i + 3);
         run_op(vecs[i], inst, pc, rwa, o);
         check_obs($sformatf("vec%0d", i), vecs[i], o, inst, pc, rwa);
      end

      // Backpressure: result held while ns_ready=0, second op waits
      @(negedge clk);
      bus.ns_ready = 1'b0;
      present(4'd0, 32'h0000_00A1, 32'h0, 1'b1, 32'h1, 32'h10, 5'd5);
      @(negedge clk);
      present(4'd0, 32'h0000_00B2, 32'h0, 1'b1, 32'h2, 32'h20, 5'd6);
      for (int i = 0; i < 4; i++) begin
         cmp("bp_ts_valid", 32'(bus.ts_valid), 32'd1);
         cmp("bp_wb_result", bus.wb_result, 32'h0000_00A1);
         cmp("bp_ts_ready", 32'(bus.ts_ready), 32'd0);
         @(negedge clk);
      end
      bus.ns_ready = 1'b1;
      @(negedge clk);
      bus.ls_valid = 1'b0;
      cmp("bp_second_valid", 32'(bus.ts_valid), 32'd1);
      cmp("bp_second_result", bus.wb_result, 32'h0000_00B2);
      @(negedge clk);
      cmp("bp_drained", 32'(bus.ts_valid), 32'd0);

      // Flush in WAIT: drain the late response, drop its data
      present(4'd3, 32'h0000_0200, 32'h0, 1'b1, 32'h3, 32'h30, 5'd7);
      @(negedge clk);
      bus.ls_valid = 1'b0;
      cmp("fw_req", 32'(bus.data_req), 32'd1);
      bus.data_gnt = 1'b1;
      @(negedge clk);
      bus.data_gnt = 1'b0;
      cmp("fw_req_dropped", 32'(bus.data_req), 32'd0);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      present(4'd0, 32'h0000_0077, 32'h0, 1'b1, 32'h4, 32'h40, 5'd8);
      for (int i = 0; i < 5; i++) begin
         cmp("fw_drain_ready", 32'(bus.ts_ready), 32'd0);
         cmp("fw_drain_valid", 32'(bus.ts_valid), 32'd0);
         @(negedge clk);
      end
      bus.data_rvalid = 1'b1;
      bus.data_rdata  = 32'hDEAD_0000;
      @(negedge clk);
      bus.data_rvalid = 1'b0;
      cmp("fw_discard_valid", 32'(bus.ts_valid), 32'd0);
      cmp("fw_ready_again", 32'(bus.ts_ready), 32'd1);
      @(negedge clk);
      bus.ls_valid = 1'b0;
      cmp("fw_next_valid", 32'(bus.ts_valid), 32'd1);
      cmp("fw_next_result", bus.wb_result, 32'h0000_0077);
      @(negedge clk);

      // Flush coincident with gnt -> drain
      present(4'd3, 32'h0000_0300, 32'h0, 1'b1, 32'h5, 32'h50, 5'd9);
      @(negedge clk);
      bus.ls_valid = 1'b0;
      cmp("fg_req", 32'(bus.data_req), 32'd1);
      bus.data_gnt = 1'b1;
      bus.flush    = 1'b1;
      @(negedge clk);
      bus.data_gnt = 1'b0;
      bus.flush    = 1'b0;
      cmp("fg_req_dropped", 32'(bus.data_req), 32'd0);
      cmp("fg_drain_ready", 32'(bus.ts_ready), 32'd0);
      @(negedge clk);
      cmp("fg_drain_ready2", 32'(bus.ts_ready), 32'd0);
      bus.data_rvalid = 1'b1;
      @(negedge clk);
      bus.data_rvalid = 1'b0;
      cmp("fg_ready_again", 32'(bus.ts_ready), 32'd1);
      cmp("fg_no_result", 32'(bus.ts_valid), 32'd0);

      // Flush in REQ without gnt -> straight back to idle
      present(4'd6, 32'h0000_0500, 32'h1234_5678, 1'b0, 32'h6, 32'h60, 5'd0);
      @(negedge clk);
      bus.ls_valid = 1'b0;
      bus.flush    = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      cmp("fr_req_dropped", 32'(bus.data_req), 32'd0);
      cmp("fr_ready", 32'(bus.ts_ready), 32'd1);

      // Async reset in the middle of a request
      present(4'd6, 32'h0000_0600, 32'h1234_5678, 1'b0, 32'h7, 32'h70, 5'd0);
      @(negedge clk);
      bus.ls_valid = 1'b0;
      cmp("ar_req", 32'(bus.data_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      cmp("ar_req_clear", 32'(bus.data_req), 32'd0);
      cmp("ar_we_clear", 32'(bus.data_we), 32'd0);
      cmp("ar_wstrb_clear", 32'(bus.data_wstrb), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      cmp("ar_ready", 32'(bus.ts_ready), 32'd1);

      // Randomized ops against the model
      for (int i = 0; i < 60; i++) begin
         v.op    = 4'($urandom_range(0, 8));
         v.addr  = $urandom;
         if ($urandom_range(0, 2) != 0)
            v.addr[1:0] = ($urandom_range(0, 1) != 0) ? 2'b00 : {1'($urandom), 1'b0};
         v.sdata = $urandom;
         v.rdata = $urandom;
         v.rw_en = 1'($urandom);
         v.gd    = $urandom_range(0, 3);
         v.rd    = $urandom_range(0, 3);
         v.e     = model(v.op, v.addr, v.sdata, v.rdata, v.rw_en);
         inst    = $urandom;
         pc      = $urandom;
         rwa     = 5'($urandom);
         run_op(v, inst, pc, rwa, o);
         check_obs($sformatf("rnd%0d", i), v, o, inst, pc, rwa);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
